// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock FIFO with packet commit/discard.
// Words are written speculatively and become visible to the reader only
// when the packet's last word (wlast) is accepted. wdrop rewinds the write
// pointer to the last commit point and discards the partial packet.
//
// Ports:
//   clk, rst (async, active-high), clr (sync clear of pointers/flags)
//   wen/wdata/wlast/wdrop  - write side; wlast commits, wdrop discards
//   ren/rdata              - read side; rdata fall-through or registered
//   near_full_mrgn / near_empty_mrgn - flag thresholds
//   full, empty, near_full, near_empty - combinational from pointers
//   over_flow, under_flow  - registered one-cycle error pulses
//   rcount                 - committed readable word count
module sync_pkt_fifo #(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wen,
    input  logic [DSIZE-1:0] wdata,
    input  logic             wlast,
    input  logic             wdrop,
    input  logic             ren,
    input  logic [ASIZE:0]   near_full_mrgn,
    input  logic [ASIZE:0]   near_empty_mrgn,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             near_full,
    output logic             near_empty,
    output logic             over_flow,
    output logic             under_flow,
    output logic [ASIZE:0]   rcount
);

    localparam int           DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_W = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] ONE_W   = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] ZERO_W  = {(ASIZE+1){1'b0}};

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] cptr_q, cptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           over_flow_q, over_flow_d;
    logic           under_flow_q, under_flow_d;

    logic [ASIZE:0] wused;
    logic           wr_acc;
    logic           rd_acc;

    // Derived occupancy, flags and accept strobes from the registered pointers.
    always_comb begin
        wused      = wptr_q - rptr_q;
        rcount     = cptr_q - rptr_q;
        full       = (wused == DEPTH_W);
        empty      = (rcount == ZERO_W);
        near_full  = ((DEPTH_W - wused) <= near_full_mrgn);
        near_empty = (rcount <= near_empty_mrgn);
        wr_acc     = wen && !full && !wdrop && !clr;
        rd_acc     = ren && !empty && !clr;
    end

    // Next-state for pointers and error pulses; clr overrides everything.
    always_comb begin
        wptr_d       = wptr_q;
        cptr_d       = cptr_q;
        rptr_d       = rptr_q;
        over_flow_d  = 1'b0;
        under_flow_d = 1'b0;
        if (clr) begin
            wptr_d = ZERO_W;
            cptr_d = ZERO_W;
            rptr_d = ZERO_W;
        end else begin
            // A drop wins over a same-cycle write, so the word and its wlast are lost.
            if (wdrop) begin
                wptr_d = cptr_q;
            end else if (wr_acc) begin
                wptr_d = wptr_q + ONE_W;
            end else begin
                wptr_d = wptr_q;
            end
            if (wr_acc && wlast) begin
                cptr_d = wptr_q + ONE_W;
            end else begin
                cptr_d = cptr_q;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + ONE_W;
            end else begin
                rptr_d = rptr_q;
            end
            over_flow_d  = wen && full && !wdrop;
            under_flow_d = ren && empty;
        end
    end

    // Pointer and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= ZERO_W;
            cptr_q       <= ZERO_W;
            rptr_q       <= ZERO_W;
            over_flow_q  <= 1'b0;
            under_flow_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            cptr_q       <= cptr_d;
            rptr_q       <= rptr_d;
            over_flow_q  <= over_flow_d;
            under_flow_q <= under_flow_d;
        end
    end

    // Storage array; deliberately not reset or cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign over_flow  = over_flow_q;
    assign under_flow = under_flow_q;

    generate
        if (FALLTHROUGH == "TRUE") begin : g_ft
            // Head word is presented combinationally; meaningless while empty.
            assign rdata = mem[rptr_q[ASIZE-1:0]];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q, rdata_d;

            // Registered read data: load on accepted read, zero on clr, else hold.
            always_comb begin
                rdata_d = rdata_q;
                if (clr) begin
                    rdata_d = {DSIZE{1'b0}};
                end else if (rd_acc) begin
                    rdata_d = mem[rptr_q[ASIZE-1:0]];
                end else begin
                    rdata_d = rdata_q;
                end
            end

            // Read data register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= {DSIZE{1'b0}};
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed self-checking bench for sync_pkt_fifo (ASIZE=2, DSIZE=8).
// One fall-through instance and one registered-read instance share clk/rst.
// A reference queue model holds speculative and committed words.
module tb_sync_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Fall-through instance signals
    logic       clr = 1'b0, wen = 1'b0, wlast = 1'b0, wdrop = 1'b0, ren = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [2:0] nfm = 3'd0, nem = 3'd0;
    logic [7:0] rdata;
    logic       full, empty, near_full, near_empty, over_flow, under_flow;
    logic [2:0] rcount;

    // Registered-read instance signals
    logic       r_clr = 1'b0, r_wen = 1'b0, r_wlast = 1'b0, r_wdrop = 1'b0, r_ren = 1'b0;
    logic [7:0] r_wdata = 8'h00;
    logic [7:0] r_rdata;
    logic       r_full, r_empty, r_near_full, r_near_empty, r_over_flow, r_under_flow;
    logic [2:0] r_rcount;

    int total = 0;
    int bad   = 0;

    logic [7:0] spec_q[$];
    logic [7:0] cq[$];
    logic [7:0] rq[$];

    always #5 clk = ~clk;

    sync_pkt_fifo #(.DSIZE(8), .ASIZE(2), .FALLTHROUGH("TRUE")) dut_ft (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata), .wlast(wlast),
        .wdrop(wdrop), .ren(ren), .near_full_mrgn(nfm), .near_empty_mrgn(nem),
        .rdata(rdata), .full(full), .empty(empty), .near_full(near_full),
        .near_empty(near_empty), .over_flow(over_flow), .under_flow(under_flow),
        .rcount(rcount)
    );

    sync_pkt_fifo #(.DSIZE(8), .ASIZE(2), .FALLTHROUGH("FALSE")) dut_reg (
        .clk(clk), .rst(rst), .clr(r_clr), .wen(r_wen), .wdata(r_wdata), .wlast(r_wlast),
        .wdrop(r_wdrop), .ren(r_ren), .near_full_mrgn(nfm), .near_empty_mrgn(nem),
        .rdata(r_rdata), .full(r_full), .empty(r_empty), .near_full(r_near_full),
        .near_empty(r_near_empty), .over_flow(r_over_flow), .under_flow(r_under_flow),
        .rcount(r_rcount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one write cycle on the fall-through instance and update the model.
    task automatic wr(input logic [7:0] d, input logic l, input logic dr);
        wen = 1'b1; wdata = d; wlast = l; wdrop = dr;
        if (dr) begin
            spec_q.delete();
        end else if (cq.size() + spec_q.size() < 4) begin
            spec_q.push_back(d);
            if (l) begin
                foreach (spec_q[i]) cq.push_back(spec_q[i]);
                spec_q.delete();
            end
        end
        tick();
        wen = 1'b0; wlast = 1'b0; wdrop = 1'b0;
    endtask

    // Compare the fall-through head against the scoreboard, then read it.
    task automatic rd(input string tag);
        logic [7:0] e;
        if (cq.size() == 0) begin
            total++; bad++;
            $error("FAIL %s observed=%0h expected=scoreboard_word", tag, rdata);
        end else begin
            e = cq.pop_front();
            chk(tag, {24'h0, rdata}, {24'h0, e});
        end
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    initial begin
        // Power-on reset
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("rst_empty",      {31'h0, empty},      32'd1);
        chk("rst_full",       {31'h0, full},       32'd0);
        chk("rst_rcount",     {29'h0, rcount},     32'd0);
        chk("rst_near_empty", {31'h0, near_empty}, 32'd1);
        chk("rst_near_full",  {31'h0, near_full},  32'd0);
        chk("rst_over_flow",  {31'h0, over_flow},  32'd0);
        chk("rst_under_flow", {31'h0, under_flow}, 32'd0);
        chk("rst_reg_rdata",  {24'h0, r_rdata},    32'd0);
        tick();

        // Reset asserted mid-packet discards the partial packet
        wr(8'hE1, 1'b0, 1'b0);
        wr(8'hE2, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_empty",  {31'h0, empty},     32'd1);
        chk("midrst_full",   {31'h0, full},      32'd0);
        chk("midrst_rcount", {29'h0, rcount},    32'd0);
        chk("midrst_ovf",    {31'h0, over_flow}, 32'd0);
        rst = 1'b0;
        spec_q.delete();
        wr(8'h11, 1'b1, 1'b0);
        chk("p11_rcount", {29'h0, rcount}, 32'd1);
        rd("p11_data");
        chk("p11_empty", {31'h0, empty}, 32'd1);

        // Three-word packet becomes visible only on the wlast edge
        wr(8'hA1, 1'b0, 1'b0);
        chk("a1_empty", {31'h0, empty}, 32'd1);
        wr(8'hA2, 1'b0, 1'b0);
        chk("a2_empty", {31'h0, empty}, 32'd1);
        wr(8'hA3, 1'b1, 1'b0);
        chk("a3_empty",  {31'h0, empty},  32'd0);
        chk("a3_rcount", {29'h0, rcount}, 32'd3);
        rd("a_data0"); rd("a_data1"); rd("a_data2");
        chk("a_drained", {31'h0, empty}, 32'd1);

        // Drop with a same-cycle write loses the whole packet
        wr(8'hB1, 1'b0, 1'b0);
        wr(8'hB2, 1'b0, 1'b0);
        wr(8'hB3, 1'b1, 1'b1);
        chk("drop_rcount", {29'h0, rcount}, 32'd0);
        chk("drop_full",   {31'h0, full},   32'd0);
        chk("drop_empty",  {31'h0, empty},  32'd1);
        wr(8'hC1, 1'b1, 1'b0);
        chk("c1_rcount", {29'h0, rcount}, 32'd1);
        rd("c1_data");
        chk("c1_empty", {31'h0, empty}, 32'd1);

        // Full, overflow, drain, underflow
        wr(8'h41, 1'b0, 1'b0);
        wr(8'h42, 1'b0, 1'b0);
        wr(8'h43, 1'b0, 1'b0);
        wr(8'h44, 1'b1, 1'b0);
        chk("full_flag",   {31'h0, full},      32'd1);
        chk("full_nfull",  {31'h0, near_full}, 32'd1);
        chk("full_rcount", {29'h0, rcount},    32'd4);
        wr(8'hFF, 1'b1, 1'b0);
        chk("ovf_pulse", {31'h0, over_flow}, 32'd1);
        tick();
        chk("ovf_clear", {31'h0, over_flow}, 32'd0);
        rd("full_d0"); rd("full_d1"); rd("full_d2"); rd("full_d3");
        chk("drain_empty", {31'h0, empty}, 32'd1);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("udf_pulse",  {31'h0, under_flow}, 32'd1);
        chk("udf_rcount", {29'h0, rcount},     32'd0);
        tick();
        chk("udf_clear", {31'h0, under_flow}, 32'd0);
        wr(8'h55, 1'b1, 1'b0);
        chk("post_udf_rcount", {29'h0, rcount}, 32'd1);
        rd("post_udf_data");

        // Streaming one-word packets with simultaneous read and write
        nem = 3'd1;
        wr(8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) begin
            logic [7:0] e;
            e = cq.pop_front();
            chk("stream_data", {24'h0, rdata}, {24'h0, e});
            cq.push_back(8'(i));
            wen = 1'b1; wdata = 8'(i); wlast = 1'b1; ren = 1'b1;
            tick();
            wen = 1'b0; wlast = 1'b0; ren = 1'b0;
            chk("stream_rcount", {29'h0, rcount},     32'd1);
            chk("stream_nempty", {31'h0, near_empty}, 32'd1);
            chk("stream_full",   {31'h0, full},       32'd0);
        end
        rd("stream_last");
        chk("stream_empty", {31'h0, empty}, 32'd1);
        nem = 3'd0;

        // Registered-read instance: one-cycle latency, hold, then clr
        r_wen = 1'b1; r_wdata = 8'hD1; r_wlast = 1'b0; rq.push_back(8'hD1);
        tick();
        r_wdata = 8'hD2; r_wlast = 1'b1; rq.push_back(8'hD2);
        tick();
        r_wen = 1'b0; r_wlast = 1'b0;
        chk("reg_rcount2", {29'h0, r_rcount}, 32'd2);
        chk("reg_rdata_pre", {24'h0, r_rdata}, 32'd0);
        r_ren = 1'b1;
        tick();
        r_ren = 1'b0;
        chk("reg_rdata", {24'h0, r_rdata}, {24'h0, rq.pop_front()});
        tick();
        chk("reg_rdata_hold", {24'h0, r_rdata}, 32'h000000D1);
        chk("reg_rcount1",    {29'h0, r_rcount}, 32'd1);
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;
        rq.delete();
        chk("clr_rdata",  {24'h0, r_rdata},  32'd0);
        chk("clr_empty",  {31'h0, r_empty},  32'd1);
        chk("clr_rcount", {29'h0, r_rcount}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
